// File: rtl/palindrome_stream_feeder_if.sv
// Handshake bundle between the upstream string source, the palindrome cell array head and the result sink.
// The feeder takes the master side; the environment around it takes the slave side.
interface palindrome_stream_feeder_if #(
    parameter int WIDTH = 4,
    parameter int LW    = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sym;
    logic             in_last;

    logic             h_valid;
    logic             h_ready;
    logic [WIDTH-1:0] h_sym;
    logic             h_start;

    logic             p_valid;
    logic             p_ready;
    logic             p_bit;

    logic             res_valid;
    logic             res_pal;
    logic [LW-1:0]    res_len;
    logic             err;

    modport master (
        input  in_valid, in_sym, in_last, h_ready, p_valid, p_bit,
        output in_ready, h_valid, h_sym, h_start, p_ready,
               res_valid, res_pal, res_len, err
    );

    modport slave (
        output in_valid, in_sym, in_last, h_ready, p_valid, p_bit,
        input  in_ready, h_valid, h_sym, h_start, p_ready,
               res_valid, res_pal, res_len, err
    );
endinterface

// File: rtl/palindrome_stream_feeder.sv
// Front end for the palindrome cell array: buffers symbols, feeds the array head with a start flag,
// retires the per-symbol verdicts in order and emits one summary result per string.
module palindrome_stream_feeder #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int MAXLEN = 15,
    parameter int LW     = $clog2(MAXLEN + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    palindrome_stream_feeder_if.master  bus
);
    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [LW-1:0] MAX_CNT   = LW'(MAXLEN);

    logic [WIDTH-1:0] symMem  [DEPTH];
    logic             lastMem [DEPTH];
    logic [AW-1:0]    fWr, fRd;
    logic [AW:0]      fCount;

    logic             qMem [DEPTH];
    logic [AW-1:0]    qWr, qRd;
    logic [AW:0]      qCount;

    logic             firstPend;
    logic [LW-1:0]    lenCnt;
    logic [LW-1:0]    lenNext;

    logic fifoFull, fifoEmpty, qFull, qEmpty;
    logic push, hValid, hFire, pFire, headLast;

    assign fifoFull  = (fCount == DEPTH_CNT);
    assign fifoEmpty = (fCount == '0);
    assign qFull     = (qCount == DEPTH_CNT);
    assign qEmpty    = (qCount == '0);

    assign push     = bus.in_valid && !fifoFull;
    assign hValid   = !fifoEmpty && !qFull;
    assign hFire    = hValid && bus.h_ready;
    assign pFire    = bus.p_valid && !qEmpty;
    assign headLast = lastMem[fRd];

    assign lenNext  = (lenCnt == MAX_CNT) ? lenCnt : lenCnt + 1'b1;

    assign bus.in_ready = !fifoFull;
    assign bus.h_valid  = hValid;
    // Stale FIFO contents are masked so h_sym reads 0 whenever nothing is offered.
    assign bus.h_sym    = hValid ? symMem[fRd] : '0;
    assign bus.h_start  = firstPend;
    assign bus.p_ready  = !qEmpty;

    always_ff @(posedge clk) begin
        if (push) begin
            symMem[fWr]  <= bus.in_sym;
            lastMem[fWr] <= bus.in_last;
        end
        if (hFire) begin
            qMem[qWr] <= headLast;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fWr    <= '0;
            fRd    <= '0;
            fCount <= '0;
        end else begin
            if (push)  fWr <= fWr + 1'b1;
            if (hFire) fRd <= fRd + 1'b1;
            case ({push, hFire})
                2'b10:   fCount <= fCount + 1'b1;
                2'b01:   fCount <= fCount - 1'b1;
                default: fCount <= fCount;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qWr       <= '0;
            qRd       <= '0;
            qCount    <= '0;
            firstPend <= 1'b1;
        end else begin
            if (hFire) begin
                qWr       <= qWr + 1'b1;
                firstPend <= headLast;
            end
            if (pFire) qRd <= qRd + 1'b1;
            case ({hFire, pFire})
                2'b10:   qCount <= qCount + 1'b1;
                2'b01:   qCount <= qCount - 1'b1;
                default: qCount <= qCount;
            endcase
        end
    end

    // Verdict retirement: the popped last flag closes the string and publishes its result.
    always_ff @(posedge clk) begin
        if (reset) begin
            lenCnt        <= '0;
            bus.res_valid <= 1'b0;
            bus.res_pal   <= 1'b0;
            bus.res_len   <= '0;
            bus.err       <= 1'b0;
        end else begin
            bus.res_valid <= 1'b0;
            if (pFire) begin
                if (lenCnt == MAX_CNT) bus.err <= 1'b1;
                if (qMem[qRd]) begin
                    bus.res_valid <= 1'b1;
                    bus.res_pal   <= bus.p_bit;
                    bus.res_len   <= lenNext;
                    lenCnt        <= '0;
                end else begin
                    lenCnt <= lenNext;
                end
            end
            if (bus.p_valid && qEmpty) bus.err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_palindrome_stream_feeder.sv
// Directed bench for palindrome_stream_feeder: a small array stand-in returns scripted verdicts
// after each head transfer, and logged transfers/results are compared against hand-computed values.
module tb_palindrome_stream_feeder;
    localparam int WIDTH  = 4;
    localparam int DEPTH  = 8;
    localparam int MAXLEN = 15;
    localparam int LW     = $clog2(MAXLEN + 1);

    logic clk;
    logic reset;

    palindrome_stream_feeder_if #(.WIDTH(WIDTH), .LW(LW)) bus ();

    palindrome_stream_feeder #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .MAXLEN(MAXLEN), .LW(LW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH:0] inQ[$];      // {sym, last}
    logic           pScript[$];  // verdicts the array will produce, in H order
    logic           retQ[$];     // verdicts ready to be returned
    logic [WIDTH:0] hLog[$];     // {h_start, h_sym}
    logic [LW:0]    resLog[$];   // {res_pal, res_len}
    logic           hRdy;
    logic           pEn;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; drives inputs for the next rising edge and logs transfers.
    task automatic tick();
        bus.in_valid = (inQ.size() != 0);
        bus.in_sym   = (inQ.size() != 0) ? inQ[0][WIDTH:1] : '0;
        bus.in_last  = (inQ.size() != 0) ? inQ[0][0] : 1'b0;
        bus.h_ready  = hRdy;
        bus.p_valid  = pEn && (retQ.size() != 0);
        bus.p_bit    = (retQ.size() != 0) ? retQ[0] : 1'b0;
        #1;
        if (bus.in_valid && bus.in_ready) void'(inQ.pop_front());
        if (bus.h_valid && bus.h_ready) begin
            hLog.push_back({bus.h_start, bus.h_sym});
            retQ.push_back((pScript.size() != 0) ? pScript.pop_front() : 1'b0);
        end
        if (bus.p_valid && bus.p_ready) void'(retQ.pop_front());
        @(posedge clk);
        @(negedge clk);
        if (bus.res_valid) resLog.push_back({bus.res_pal, bus.res_len});
    endtask

    task automatic runIdle(input int budget);
        int n = 0;
        while ((inQ.size() != 0 || retQ.size() != 0 || bus.h_valid) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) checkVal("idle_timeout", 32'd1, 32'd0);
        tick();
        tick();
    endtask

    task automatic doReset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.p_valid  = 1'b0;
        bus.h_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        inQ.delete();
        pScript.delete();
        retQ.delete();
        hLog.delete();
        resLog.delete();
    endtask

    task automatic clearLogs();
        hLog.delete();
        resLog.delete();
    endtask

    task automatic checkIdleState(input string tag);
        checkVal({tag, "_h_valid"},   32'(bus.h_valid),   32'd0);
        checkVal({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        checkVal({tag, "_h_start"},   32'(bus.h_start),   32'd1);
        checkVal({tag, "_p_ready"},   32'(bus.p_ready),   32'd0);
        checkVal({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        checkVal({tag, "_err"},       32'(bus.err),       32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sym   = '0;
        bus.in_last  = 1'b0;
        bus.h_ready  = 1'b0;
        bus.p_valid  = 1'b0;
        bus.p_bit    = 1'b0;
        hRdy = 1'b1;
        pEn  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: reset state
        checkIdleState("t1");
        checkVal("t1_h_sym",   32'(bus.h_sym),   32'd0);
        checkVal("t1_res_pal", 32'(bus.res_pal), 32'd0);
        checkVal("t1_res_len", 32'(bus.res_len), 32'd0);

        // 2: "3,5,3" with verdicts 1,0,1
        inQ = '{{4'd3, 1'b0}, {4'd5, 1'b0}, {4'd3, 1'b1}};
        pScript = '{1'b1, 1'b0, 1'b1};
        runIdle(100);
        checkVal("t2_h_count", 32'(hLog.size()), 32'd3);
        checkVal("t2_h0", 32'(hLog[0]), 32'h13);
        checkVal("t2_h1", 32'(hLog[1]), 32'h05);
        checkVal("t2_h2", 32'(hLog[2]), 32'h03);
        checkVal("t2_res_count", 32'(resLog.size()), 32'd1);
        checkVal("t2_res0", 32'(resLog[0]), 32'h13);   // pal=1, len=3
        checkVal("t2_err", 32'(bus.err), 32'd0);
        checkVal("t2_hold_pal", 32'(bus.res_pal), 32'd1);
        checkVal("t2_hold_len", 32'(bus.res_len), 32'd3);

        // 3: back-to-back "7" and "1,2"
        clearLogs();
        inQ = '{{4'd7, 1'b1}, {4'd1, 1'b0}, {4'd2, 1'b1}};
        pScript = '{1'b1, 1'b1, 1'b0};
        runIdle(100);
        checkVal("t3_h_count", 32'(hLog.size()), 32'd3);
        checkVal("t3_h0", 32'(hLog[0]), 32'h17);
        checkVal("t3_h1", 32'(hLog[1]), 32'h11);
        checkVal("t3_h2", 32'(hLog[2]), 32'h02);
        checkVal("t3_res_count", 32'(resLog.size()), 32'd2);
        checkVal("t3_res0", 32'(resLog[0]), 32'h11);   // pal=1, len=1
        checkVal("t3_res1", 32'(resLog[1]), 32'h02);   // pal=0, len=2

        // 4: H stalled, DEPTH+2 symbols offered
        clearLogs();
        hRdy = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) inQ.push_back({4'(i), (i == DEPTH + 1) ? 1'b1 : 1'b0});
        for (int i = 0; i < DEPTH + 2; i++) pScript.push_back((i == DEPTH + 1) ? 1'b1 : 1'b0);
        repeat (12) tick();
        checkVal("t4_accepted", 32'(inQ.size()), 32'd2);
        checkVal("t4_in_ready", 32'(bus.in_ready), 32'd0);
        checkVal("t4_h_valid",  32'(bus.h_valid), 32'd1);
        checkVal("t4_h_sym",    32'(bus.h_sym), 32'd0);
        hRdy = 1'b1;
        runIdle(200);
        checkVal("t4_h_count", 32'(hLog.size()), 32'd10);
        for (int i = 0; i < DEPTH + 2; i++)
            checkVal($sformatf("t4_h%0d", i), 32'(hLog[i]), (i == 0) ? 32'h10 : 32'(i));
        checkVal("t4_res_count", 32'(resLog.size()), 32'd1);
        checkVal("t4_res0", 32'(resLog[0]), 32'h1A);   // pal=1, len=10

        // 5: verdicts withheld, 10 symbols
        clearLogs();
        pEn = 1'b0;
        for (int i = 0; i < 10; i++) inQ.push_back({4'(15 - i), (i == 9) ? 1'b1 : 1'b0});
        for (int i = 0; i < 10; i++) pScript.push_back((i == 9) ? 1'b0 : 1'b1);
        repeat (20) tick();
        checkVal("t5_h_count_stalled", 32'(hLog.size()), 32'd8);
        checkVal("t5_h_valid", 32'(bus.h_valid), 32'd0);
        checkVal("t5_p_ready", 32'(bus.p_ready), 32'd1);
        pEn = 1'b1;
        runIdle(200);
        checkVal("t5_h_count", 32'(hLog.size()), 32'd10);
        checkVal("t5_h8", 32'(hLog[8]), 32'h07);
        checkVal("t5_h9", 32'(hLog[9]), 32'h06);
        checkVal("t5_res_count", 32'(resLog.size()), 32'd1);
        checkVal("t5_res0", 32'(resLog[0]), 32'h0A);   // pal=0, len=10
        checkVal("t5_err", 32'(bus.err), 32'd0);

        // unsolicited verdict
        bus.p_valid = 1'b1;
        bus.p_bit   = 1'b1;
        #1;
        checkVal("tu_p_ready", 32'(bus.p_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.p_valid = 1'b0;
        checkVal("tu_err", 32'(bus.err), 32'd1);
        checkVal("tu_res_valid", 32'(bus.res_valid), 32'd0);
        doReset();
        checkIdleState("tu_rst");

        // 6: 17-symbol string overflows MAXLEN
        for (int i = 0; i < 17; i++) inQ.push_back({4'(i % 16), (i == 16) ? 1'b1 : 1'b0});
        for (int i = 0; i < 17; i++) pScript.push_back(1'b1);
        runIdle(300);
        checkVal("t6_h_count", 32'(hLog.size()), 32'd17);
        checkVal("t6_res_count", 32'(resLog.size()), 32'd1);
        checkVal("t6_res0", 32'(resLog[0]), 32'h1F);   // pal=1, len=15 saturated
        checkVal("t6_err", 32'(bus.err), 32'd1);

        // 6b: reset mid-string drops everything
        clearLogs();
        for (int i = 0; i < 5; i++) inQ.push_back({4'(i + 2), 1'b0});
        for (int i = 0; i < 5; i++) pScript.push_back(1'b1);
        repeat (3) tick();
        checkVal("t6b_pre_h_count", 32'(hLog.size() > 0), 32'd1);
        doReset();
        checkIdleState("t6b_rst");
        repeat (5) tick();
        checkVal("t6b_res_count", 32'(resLog.size()), 32'd0);
        checkVal("t6b_h_count", 32'(hLog.size()), 32'd0);
        checkIdleState("t6b_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
